// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Small synchronous FIFO between instruction fetch and decode. Each entry
//   holds {pc, instr, fault}. The head is presented to decode together with
//   the 19-bit pre-decode field and a "not a 32-bit encoding" flag. A flush
//   empties the queue in one cycle on any redirect.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           discard all entries (wins over push/pop)
//   in_valid/ready  fetch-side handshake; in_pc/in_instr/in_fault payload
//   out_valid/ready decode-side handshake
//   out_pc/out_instr/out_fault   head entry, forced to 0 when empty
//   out_dec_field   {instr[31:25], instr[21:20], instr[14:12], instr[6:0]}
//   out_not32       head instr[1:0] != 2'b11, gated by out_valid
//   count           current occupancy
module fetch_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     in_fault,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [18:0]              out_dec_field,
  output logic                     out_fault,
  output logic                     out_not32,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0] fault_q;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push, pop;
  logic [XLEN-1:0] head_instr;

  // Handshakes depend only on registered occupancy, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_q[wr_ptr_q]    <= in_pc;
      instr_q[wr_ptr_q] <= in_instr;
      fault_q[wr_ptr_q] <= in_fault;
    end
  end

  // Empty queue drives zeros so a stale head never reaches decode.
  assign out_pc     = out_valid ? pc_q[rd_ptr_q]    : '0;
  assign head_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_instr  = head_instr;
  assign out_fault  = out_valid & fault_q[rd_ptr_q];
  assign out_not32  = out_valid & (head_instr[1:0] != 2'b11);
  assign out_dec_field = {head_instr[31:25], head_instr[21:20],
                          head_instr[14:12], head_instr[6:0]};
  assign count      = count_q;

  a_count_max : assert property (@(posedge clk) disable iff (rst)
    count_q <= FULL);
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(pop && count_q == '0));
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(push && count_q == FULL));
  a_ptr_count : assert property (@(posedge clk) disable iff (rst)
    (wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              in_valid, in_ready;
  logic [XLEN-1:0]   in_pc, in_instr;
  logic              in_fault;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_pc, out_instr;
  logic [18:0]       out_dec_field;
  logic              out_fault, out_not32;
  logic [2:0]        count;

  always #5 clk = ~clk;

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_fault(in_fault),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_dec_field(out_dec_field),
    .out_fault(out_fault), .out_not32(out_not32), .count(count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t mq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int seen_200 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pre-decode field built arithmetically from the instruction word.
  function automatic logic [18:0] dec_of(input logic [31:0] i);
    int unsigned v;
    v = (((i >> 25) & 32'h7f) << 12) | (((i >> 20) & 32'h3) << 10) |
        (((i >> 12) & 32'h7) << 7) | (i & 32'h7f);
    return v[18:0];
  endfunction

  task automatic check_model(input string tag);
    ent_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, ".valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({tag, ".ready"}, 64'(in_ready),  64'(mq.size() < DEPTH));
    chk({tag, ".count"}, 64'(count),     64'(mq.size()));
    chk({tag, ".pc"},    64'(out_pc),    64'(h.pc));
    chk({tag, ".instr"}, 64'(out_instr), 64'(h.instr));
    chk({tag, ".fault"}, 64'(out_fault), 64'(h.fault));
    chk({tag, ".not32"}, 64'(out_not32),
        64'((mq.size() > 0) && (h.instr % 4 != 3)));
    chk({tag, ".dec"},   64'(out_dec_field), 64'(dec_of(h.instr)));
    if (out_valid && out_pc == 32'h200) seen_200++;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic f, input logic ordy, input logic fl, input logic r);
    in_valid = v; in_pc = pc; in_instr = ins; in_fault = f;
    out_ready = ordy; flush = fl; rst = r;
  endtask

  // One clock: model follows the rules sampled at the edge, then re-check.
  task automatic step(input string tag);
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && (mq.size() < DEPTH);
    pp  = out_ready && (mq.size() > 0);
    if (rst || flush) mq.delete();
    else begin
      if (pp)  void'(mq.pop_front());
      if (acc) mq.push_back('{in_pc, in_instr, in_fault});
    end
    @(negedge clk);
    check_model(tag);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(3) != 0) w[1:0] = 2'b11;
    return w;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    step("rst0");
    step("rst1");
    drive(0, 0, 0, 0, 0, 0, 0);
    step("idle");
    chk("idle.count_lit", 64'(count), 64'd0);
    chk("idle.ready_lit", 64'(in_ready), 64'd1);

    // single pass-through
    drive(1, 32'h100, 32'h00A00093, 0, 1, 0, 0);
    step("pt_push");
    chk("pt.pc_lit",  64'(out_pc), 64'h100);
    chk("pt.dec_lit", 64'(out_dec_field), 64'(19'b0000000_10_000_0010011));
    drive(0, 0, 0, 0, 1, 0, 0);
    step("pt_pop");
    chk("pt.empty_lit", 64'(out_valid), 64'd0);

    // fill and stall
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'(i * 4), rnd_instr(), 0, 0, 0, 0);
      if (i == 4) chk("fill.ready_full", 64'(in_ready), 64'd0);
      step("fill");
    end
    chk("fill.count_lit", 64'(count), 64'd4);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain.head_lit", 64'(out_pc), 64'(i * 4));
      step("drain");
      if (i == 0) chk("drain.ready_back", 64'(in_ready), 64'd1);
    end

    // wrap-around with concurrent push/pop
    for (int i = 0; i < 20; i++) begin
      if (i > 0) chk("wrap.head_seq", 64'(out_pc), 64'(32'h1000 + 4 * (i - 1)));
      drive(1, 32'h1000 + 32'(4 * i), rnd_instr(), 0, 1, 0, 0);
      step("wrap");
      chk("wrap.count1", 64'(count), 64'd1);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    step("wrap_drain");

    // flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(4 * i), rnd_instr(), 0, 0, 0, 0);
      step("pre_flush");
    end
    chk("flush.count3", 64'(count), 64'd3);
    drive(1, 32'h200, rnd_instr(), 0, 1, 1, 0);
    step("flush");
    chk("flush.count0", 64'(count), 64'd0);
    drive(1, 32'h200, rnd_instr(), 0, 1, 1, 0);
    step("flush_b2b");
    drive(0, 0, 0, 0, 1, 0, 0);
    step("post_flush");
    step("post_flush2");
    chk("flush.no_200", 64'(seen_200), 64'd0);

    // fault and non-32-bit flags, then reset while occupied
    drive(1, 32'h400, 32'h00000001, 1, 0, 0, 0);
    step("fault");
    chk("fault.flag_lit",  64'(out_fault), 64'd1);
    chk("fault.not32_lit", 64'(out_not32), 64'd1);
    drive(1, 32'h404, rnd_instr(), 0, 0, 0, 0);
    step("fault2");
    chk("fault.count2", 64'(count), 64'd2);
    drive(1, 32'h408, rnd_instr(), 1, 1, 0, 1);
    step("rst_busy");
    chk("rst_busy.pc0", 64'(out_pc), 64'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) != 0, $urandom, rnd_instr(), $urandom_range(7) == 0,
            $urandom_range(2) != 0, $urandom_range(15) == 0, $urandom_range(63) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
